// File: rtl/dma_pkg.sv
// dma_pkg: shared DMA descriptor, error, status and FSM state types.
`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 2
`endif
package dma_pkg;
  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] num_bytes;
  } s_dma_desc_t;
  typedef enum logic [1:0] {DMA_NO_ERR, DMA_AXI_RD_ERR, DMA_AXI_WR_ERR} dma_err_src_t;
  typedef struct packed {
    logic [31:0]  addr;
    dma_err_src_t src;
    logic         valid;
  } s_dma_error_t;
  typedef struct packed {
    logic active;
    logic done;
    logic error;
  } s_dma_status_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} dma_st_t;
endpackage

// File: rtl/dma_sched_arb.sv
// dma_sched_arb: descriptor slot arbiter; DMA_SCHED_RR_EN selects round-robin,
// otherwise fixed priority with the lowest index winning.
module dma_sched_arb #(
  parameter int N = 2,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx
);
  logic          found;
  logic [IW-1:0] j;
  logic [IW-1:0] base;
`ifdef DMA_SCHED_RR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) base <= '0;
    else if (accept) base <= gnt_idx == IW'(N - 1) ? '0 : gnt_idx + 1'b1;
`else
  logic unused_ok;
  assign base = '0;
  assign unused_ok = ^{clk, rst_n, accept};
`endif
  always_comb begin
    found = 1'b0;
    gnt_idx = '0;
    j = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(base) + i) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        gnt_idx = j;
      end
    end
    gnt_oh = found ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/dma_desc_sched.sv
// dma_desc_sched: grants descriptor slots to a single streamer and tracks sticky done/error;
// DMA_SCHED_RR_EN enables round-robin slot arbitration in dma_sched_arb.
`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 2
`endif
module dma_desc_sched
  import dma_pkg::*;
#(
  parameter int NUM_DESC = `DMA_NUM_DESC,
  parameter int IW = NUM_DESC > 1 ? $clog2(NUM_DESC) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  s_dma_desc_t [NUM_DESC-1:0]   desc_i,
  input  logic [NUM_DESC-1:0]          desc_valid_i,
  output logic [NUM_DESC-1:0]          desc_ack_o,
  output logic [NUM_DESC-1:0]          desc_done_o,
  output s_dma_desc_t                  strm_desc_o,
  output logic                         strm_start_o,
  input  logic                         strm_done_i,
  input  s_dma_error_t                 strm_err_i,
  input  logic                         clear_i,
  output s_dma_status_t                status_o,
  output s_dma_error_t                 error_o,
  output logic [IW-1:0]                active_id_o
);
  dma_st_t             state, next;
  s_dma_desc_t         desc_q;
  s_dma_error_t        err_q;
  logic [IW-1:0]       id_q, gnt_idx;
  logic [NUM_DESC-1:0] gnt_oh;
  logic                accept, done_q, start_q;
  dma_sched_arb #(.N(NUM_DESC), .IW(IW)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (desc_valid_i),
    .accept  (accept),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // ack is combinational so the slot sees it in the grant cycle; forced low while in reset
  always_comb begin
    next = state;
    accept = 1'b0;
    desc_ack_o = '0;
    desc_done_o = '0;
    case (state)
      IDLE: begin
        accept = |desc_valid_i && !err_q.valid;
        desc_ack_o = (accept && rst_n) ? gnt_oh : '0;
        next = !accept ? IDLE : desc_i[gnt_idx].num_bytes == '0 ? DONE : RUN;
      end
      RUN:  next = (strm_done_i || strm_err_i.valid) ? DONE : RUN;
      DONE: begin
        desc_done_o = NUM_DESC'(1) << id_q;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      desc_q <= '0;
      id_q <= '0;
      err_q <= '0;
      done_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= accept && next == RUN;
      if (accept) begin
        desc_q <= desc_i[gnt_idx];
        id_q <= gnt_idx;
      end
      if (state == RUN && strm_err_i.valid) err_q <= strm_err_i;
      else if (state == IDLE && clear_i) err_q <= '0;
      done_q <= state == DONE ? 1'b1 : (state == IDLE && clear_i) ? 1'b0 : done_q;
    end
  assign strm_desc_o = desc_q;
  assign strm_start_o = start_q;
  assign error_o = err_q;
  assign active_id_o = id_q;
  assign status_o = '{active: state != IDLE, done: done_q, error: err_q.valid};
endmodule

// File: tb/tb_dma_desc_sched.sv
// tb_dma_desc_sched: directed self-checking bench for dma_desc_sched.
module tb_dma_desc_sched;
  import dma_pkg::*;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  s_dma_desc_t [1:0] desc;
  logic [1:0]        valid, ack, done_p;
  s_dma_desc_t       sdesc;
  logic              start, sdone, clear;
  s_dma_error_t      serr, err, exp_err;
  s_dma_status_t     status;
  logic [0:0]        aid;
  int                total = 0;
  int                bad = 0;

  dma_desc_sched #(.NUM_DESC(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .desc_i       (desc),
    .desc_valid_i (valid),
    .desc_ack_o   (ack),
    .desc_done_o  (done_p),
    .strm_desc_o  (sdesc),
    .strm_start_o (start),
    .strm_done_i  (sdone),
    .strm_err_i   (serr),
    .clear_i      (clear),
    .status_o     (status),
    .error_o      (err),
    .active_id_o  (aid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = '0; sdone = 1'b0; serr = '0; clear = 1'b0; desc = '0;
    tick; tick;
    total++; if ({ack, done_p, start} !== 5'b0) begin bad++; $display("FAIL reset_pulses got=%b exp=00000", {ack, done_p, start}); end
    total++; if (sdesc !== '0) begin bad++; $display("FAIL reset_desc got=%h exp=0", sdesc); end
    total++; if ({status, err, aid} !== '0) begin bad++; $display("FAIL reset_state got=%h exp=0", {status, err, aid}); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    desc[0] = '{src_addr: 32'h1000, dst_addr: 32'h2000, num_bytes: 32'h40};
    valid = 2'b01;
    #1;
    total++; if (ack !== 2'b01) begin bad++; $display("FAIL basic_ack got=%b exp=01", ack); end
    tick;
    valid = 2'b00;
    total++; if (start !== 1'b1 || ack !== 2'b00) begin bad++; $display("FAIL basic_start got=%b/%b exp=1/00", start, ack); end
    total++; if (sdesc !== desc[0]) begin bad++; $display("FAIL basic_desc got=%h exp=%h", sdesc, desc[0]); end
    total++; if (aid !== 1'b0 || status.active !== 1'b1) begin bad++; $display("FAIL basic_active got=%b/%b exp=0/1", aid, status.active); end
    for (int c = 0; c < 9; c++) begin
      tick;
      total++; if (start !== 1'b0 || done_p !== 2'b00) begin bad++; $display("FAIL basic_run got=%b/%b exp=0/00", start, done_p); end
    end
    sdone = 1'b1;
    tick;
    sdone = 1'b0;
    total++; if (done_p !== 2'b01) begin bad++; $display("FAIL basic_done got=%b exp=01", done_p); end
    tick;
    total++; if (done_p !== 2'b00 || status !== 3'b010) begin bad++; $display("FAIL basic_status got=%b/%b exp=00/010", done_p, status); end
  endtask

  task automatic test_zero_len;
    desc[1] = '{src_addr: 32'h3000, dst_addr: 32'h4000, num_bytes: 32'h0};
    valid = 2'b10;
    #1;
    total++; if (ack !== 2'b10) begin bad++; $display("FAIL zero_ack got=%b exp=10", ack); end
    tick;
    valid = 2'b00;
    total++; if (done_p !== 2'b10 || start !== 1'b0 || aid !== 1'b1) begin bad++; $display("FAIL zero_done got=%b/%b/%b exp=10/0/1", done_p, start, aid); end
    tick;
    total++; if (done_p !== 2'b00 || start !== 1'b0 || err.valid !== 1'b0) begin bad++; $display("FAIL zero_after got=%b/%b/%b exp=00/0/0", done_p, start, err.valid); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp;
    desc[1].num_bytes = 32'h20;
    valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef DMA_SCHED_RR_EN
      exp = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp = 2'b01;
`endif
      #1;
      total++; if (ack !== exp) begin bad++; $display("FAIL b2b_ack%0d got=%b exp=%b", i, ack, exp); end
      tick;
      total++; if (start !== 1'b1) begin bad++; $display("FAIL b2b_start%0d got=%b exp=1", i, start); end
      sdone = 1'b1;
      tick;
      sdone = 1'b0;
      total++; if (done_p !== exp) begin bad++; $display("FAIL b2b_done%0d got=%b exp=%b", i, done_p, exp); end
      tick;
    end
    valid = 2'b10;
    #1;
    total++; if (ack !== 2'b10) begin bad++; $display("FAIL b2b_slot1 got=%b exp=10", ack); end
    tick;
    valid = 2'b00;
    sdone = 1'b1;
    tick;
    sdone = 1'b0;
    tick;
  endtask

  task automatic test_error;
    exp_err = '{addr: 32'h2040, src: DMA_AXI_WR_ERR, valid: 1'b1};
    valid = 2'b01;
    tick;
    valid = 2'b00;
    serr = exp_err;
    sdone = 1'b1;
    tick;
    serr = '0;
    sdone = 1'b0;
    total++; if (done_p !== 2'b01) begin bad++; $display("FAIL err_done got=%b exp=01", done_p); end
    total++; if (err !== exp_err || status.error !== 1'b1) begin bad++; $display("FAIL err_capture got=%h/%b exp=%h/1", err, status.error, exp_err); end
    tick;
    valid = 2'b01;
    #1;
    total++; if (ack !== 2'b00) begin bad++; $display("FAIL err_block got=%b exp=00", ack); end
    tick;
    total++; if (ack !== 2'b00 || status.active !== 1'b0 || err !== exp_err) begin bad++; $display("FAIL err_hold got=%b/%b/%h exp=00/0/%h", ack, status.active, err, exp_err); end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    total++; if (err !== '0 || status !== 3'b000) begin bad++; $display("FAIL err_clear got=%h/%b exp=0/000", err, status); end
    total++; if (ack !== 2'b01) begin bad++; $display("FAIL err_regrant got=%b exp=01", ack); end
    tick;
    valid = 2'b00;
    sdone = 1'b1;
    tick;
    sdone = 1'b0;
    tick;
  endtask

  task automatic test_clear;
    valid = 2'b01;
    clear = 1'b1;
    #1;
    total++; if (ack !== 2'b01) begin bad++; $display("FAIL clr_grant_ack got=%b exp=01", ack); end
    tick;
    clear = 1'b0;
    valid = 2'b00;
    total++; if (status.done !== 1'b0 || start !== 1'b1) begin bad++; $display("FAIL clr_grant got=%b/%b exp=0/1", status.done, start); end
    sdone = 1'b1;
    tick;
    sdone = 1'b0;
    tick;
    valid = 2'b01;
    tick;
    valid = 2'b00;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    total++; if (status.done !== 1'b1) begin bad++; $display("FAIL clr_in_run got=%b exp=1", status.done); end
    sdone = 1'b1;
    tick;
    sdone = 1'b0;
    tick;
    sdone = 1'b1;
    tick;
    sdone = 1'b0;
    total++; if (status.active !== 1'b0 || done_p !== 2'b00) begin bad++; $display("FAIL stray_done got=%b/%b exp=0/00", status.active, done_p); end
  endtask

  task automatic test_reset_mid;
    valid = 2'b01;
    tick;
    rst_n = 1'b0;
    #1;
    total++; if ({ack, done_p, start, status, aid} !== '0 || sdesc !== '0) begin bad++; $display("FAIL rst_mid got=%b/%h exp=0/0", {ack, done_p, start, status, aid}, sdesc); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    total++; if (ack !== 2'b01 || done_p !== 2'b00) begin bad++; $display("FAIL rst_regrant got=%b/%b exp=01/00", ack, done_p); end
    tick;
    valid = 2'b00;
    total++; if (start !== 1'b1 || done_p !== 2'b00) begin bad++; $display("FAIL rst_restart got=%b/%b exp=1/00", start, done_p); end
    sdone = 1'b1;
    tick;
    sdone = 1'b0;
    total++; if (done_p !== 2'b01) begin bad++; $display("FAIL rst_done got=%b exp=01", done_p); end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_len;
    test_back_to_back;
    test_error;
    test_clear;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_desc_sched.md
DMA_DESC_SCHED -- requirements
Module: dma_desc_sched

Interface
REQ-001 SHALL have parameter NUM_DESC, default `DMA_NUM_DESC (2), giving the number of descriptor slots arbitrated.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port desc_i, input, NUM_DESC x s_dma_desc_t: per-slot descriptor from the CSR block.
REQ-005 SHALL have port desc_valid_i, input, NUM_DESC: per-slot go request, level, held until acknowledged.
REQ-006 SHALL have port desc_ack_o, output, NUM_DESC: one-cycle pulse when the slot's descriptor is latched.
REQ-007 SHALL have port desc_done_o, output, NUM_DESC: one-cycle pulse when the slot's transfer completes, with or without error.
REQ-008 SHALL have port strm_desc_o, output, s_dma_desc_t: latched descriptor to the streamer.
REQ-009 SHALL have port strm_start_o, output, 1: one-cycle start pulse to the streamer.
REQ-010 SHALL have port strm_done_i, input, 1: streamer completion pulse.
REQ-011 SHALL have port strm_err_i, input, s_dma_error_t: streamer/AXI error, qualified by .valid.
REQ-012 SHALL have port clear_i, input, 1: software clear of the sticky done and error state.
REQ-013 SHALL have ports status_o (s_dma_status_t), error_o (s_dma_error_t) and active_id_o ($clog2(NUM_DESC) bits), all outputs.

Function
REQ-014 SHALL implement FSM dma_st_t with states IDLE, RUN and DONE.
REQ-015 IDLE: when any desc_valid_i is high and no sticky error is held, SHALL grant one slot, latch its descriptor into strm_desc_o, pulse desc_ack_o[grant], set active_id_o = grant, and go to RUN (num_bytes != 0) or DONE (num_bytes == 0).
REQ-016 On the IDLE->RUN transition, SHALL assert strm_start_o for exactly one cycle.
REQ-017 A zero-length descriptor SHALL NOT raise strm_start_o, and SHALL complete one cycle later with no error.
REQ-018 RUN: SHALL hold strm_desc_o stable, go to DONE on strm_done_i or strm_err_i.valid, and ignore desc_valid_i.
REQ-019 When strm_done_i and strm_err_i.valid occur in the same cycle, SHALL treat the transfer as errored.
REQ-020 On error, SHALL capture strm_err_i into error_o, with valid held sticky.
REQ-021 DONE: SHALL pulse desc_done_o[active_id_o] for one cycle, set status_o.done sticky, and return to IDLE; the ack-to-ack gap between back-to-back descriptors is therefore the streamer time plus 2 cycles.
REQ-022 status_o.active SHALL be 1 in RUN and DONE; status_o.error SHALL equal error_o.valid.
REQ-023 While error_o.valid is set, SHALL not grant new descriptors; pending valids wait.
REQ-024 clear_i in IDLE SHALL clear status_o.done and error_o in the next cycle.
REQ-025 clear_i in RUN or DONE SHALL be ignored.
REQ-026 clear_i in the same cycle as a grant SHALL take effect, and the grant SHALL proceed.
REQ-027 A strm_done_i outside RUN SHALL be ignored.

Reset
REQ-028 On rst_n low, SHALL set the state to IDLE and drive to 0 all of: outputs, latched descriptor, active_id_o, arbitration pointer, sticky bits.
REQ-029 Reset mid-transfer SHALL abandon the transfer and emit no desc_done_o pulse.

Configuration
REQ-030 With DMA_SCHED_RR_EN defined, SHALL use round-robin arbitration: priority starts at slot (last grant + 1) mod NUM_DESC; the pointer resets to slot 0.
REQ-031 Without DMA_SCHED_RR_EN, SHALL use fixed priority, lowest index wins, with no pointer register.

Structure
REQ-032 SHALL reuse s_dma_desc_t, s_dma_error_t, s_dma_status_t and dma_st_t from dma_pkg, adding no new package types.
REQ-033 SHALL place the arbiter in sub-module dma_sched_arb (request vector in, one-hot/index grant out, pointer update on accept), with the macro applied inside it.

Verification
REQ-034 Slot0 {src 0x1000, dst 0x2000, len 0x40}; done 10 cycles after start -> one ack0 at grant, start the next cycle, done0 one cycle after strm_done_i, status.done=1.
REQ-035 Both slots valid continuously, RR_EN defined -> grants 0,1,0,1; RR_EN undefined -> grant 0 repeatedly until slot0 drops.
REQ-036 Slot1 len=0 -> ack1 then done1 on the next cycle, strm_start_o never high, error_o.valid=0.
REQ-037 strm_err_i {addr 0x2040, src DMA_AXI_WR_ERR} with strm_done_i in the same cycle -> error_o captured, status.error=1, done pulse issued, no further grants until clear_i in IDLE, then the next grant occurs.
REQ-038 rst_n low during RUN -> all outputs 0 asynchronously; after release, pending slot re-granted from IDLE with no stale done pulse.
